// File: rtl/vga_timing_generator.sv
// Free-running VGA raster timing source: registered hsync/vsync, display_enable, pixel_x/pixel_y and line/frame pulses.
// Optional 8-bit completed-frame counter on o_frame_count when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       i_pixel_clk,
    input  logic       i_reset,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_display_enable,
    output logic [9:0] o_pixel_x,
    output logic [9:0] o_pixel_y,
    output logic       o_line_start,
`ifdef VGA_FRAME_COUNTER_EN
    output logic       o_frame_start,
    output logic [7:0] o_frame_count
`else
    output logic       o_frame_start
`endif
);

    localparam int CW      = 10;
    localparam int BW      = CW + 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Axis 0 is horizontal, axis 1 is vertical; boundaries kept one bit wider so a 1024 total still compares cleanly.
    localparam logic [1:0][BW-1:0] P_TOTAL      = {BW'(V_TOTAL), BW'(H_TOTAL)};
    localparam logic [1:0][BW-1:0] P_ACTIVE     = {BW'(V_ACTIVE), BW'(H_ACTIVE)};
    localparam logic [1:0][BW-1:0] P_SYNC_START = {BW'(V_ACTIVE + V_FP), BW'(H_ACTIVE + H_FP)};
    localparam logic [1:0][BW-1:0] P_SYNC_END   = {BW'(V_ACTIVE + V_FP + V_SYNC),
                                                   BW'(H_ACTIVE + H_FP + H_SYNC)};

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    function automatic phase_t phase_of(input logic [BW-1:0] cnt, input logic axis);
        phase_t ph;
        if (cnt < P_ACTIVE[axis]) begin
            ph = PH_ACTIVE;
        end else if (cnt < P_SYNC_START[axis]) begin
            ph = PH_FP;
        end else if (cnt < P_SYNC_END[axis]) begin
            ph = PH_SYNC;
        end else begin
            ph = PH_BP;
        end
        return ph;
    endfunction

    logic [CW-1:0] w_cnt_next [2];
    logic [1:0]    w_wrap;
    logic [1:0]    w_step;
    logic [1:0]    w_sync_next;
    logic [1:0]    w_active_next;
    logic          w_line_start_next;
    logic          w_frame_start_next;

    // The vertical axis only advances on the edge where the horizontal counter wraps.
    assign w_step = {w_wrap[0], 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic          AX          = 1'(gi);
            localparam logic [CW-1:0] LAST        = CW'(P_TOTAL[AX] - 1'b1);
            localparam phase_t        RESET_PHASE = phase_of({1'b0, LAST}, AX);

            logic [CW-1:0] r_cnt;
            logic [BW-1:0] w_cnt_ext;
            phase_t        r_phase;
            phase_t        w_phase_next;

            assign w_wrap[AX]     = (r_cnt == LAST);
            assign w_cnt_next[AX] = !w_step[AX] ? r_cnt :
                                    (w_wrap[AX] ? '0 : r_cnt + 1'b1);
            assign w_cnt_ext      = {1'b0, w_cnt_next[AX]};

            // Later boundaries are tested first so zero-length phases collapse onto the following one.
            always_comb begin
                w_phase_next = r_phase;
                if (w_step[AX]) begin
                    if (w_cnt_ext == '0) begin
                        w_phase_next = PH_ACTIVE;
                    end else if (w_cnt_ext == P_SYNC_END[AX]) begin
                        w_phase_next = PH_BP;
                    end else if (w_cnt_ext == P_SYNC_START[AX]) begin
                        w_phase_next = PH_SYNC;
                    end else if (w_cnt_ext == P_ACTIVE[AX]) begin
                        w_phase_next = PH_FP;
                    end
                end
            end

            always_ff @(posedge i_pixel_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_cnt   <= LAST;
                    r_phase <= RESET_PHASE;
                end else begin
                    r_cnt   <= w_cnt_next[AX];
                    r_phase <= w_phase_next;
                end
            end

            assign w_sync_next[AX]   = (w_phase_next == PH_SYNC);
            assign w_active_next[AX] = (w_phase_next == PH_ACTIVE);
        end
    endgenerate

    assign w_line_start_next  = (w_cnt_next[0] == '0);
    assign w_frame_start_next = w_line_start_next && (w_cnt_next[1] == '0);

    logic          r_hsync;
    logic          r_vsync;
    logic          r_display_enable;
    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_line_start;
    logic          r_frame_start;

    // Every port is registered from next-count decodes so it moves on the same edge as its counter.
    always_ff @(posedge i_pixel_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hsync          <= ~SYNC_POL;
            r_vsync          <= ~SYNC_POL;
            r_display_enable <= 1'b0;
            r_pixel_x        <= '0;
            r_pixel_y        <= '0;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else begin
            r_hsync          <= w_sync_next[0] ? SYNC_POL : ~SYNC_POL;
            r_vsync          <= w_sync_next[1] ? SYNC_POL : ~SYNC_POL;
            r_display_enable <= &w_active_next;
            r_pixel_x        <= w_cnt_next[0];
            r_pixel_y        <= w_cnt_next[1];
            r_line_start     <= w_line_start_next;
            r_frame_start    <= w_frame_start_next;
        end
    end

    assign o_hsync          = r_hsync;
    assign o_vsync          = r_vsync;
    assign o_display_enable = r_display_enable;
    assign o_pixel_x        = r_pixel_x;
    assign o_pixel_y        = r_pixel_y;
    assign o_line_start     = r_line_start;
    assign o_frame_start    = r_frame_start;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] r_frame_count;
    logic       r_frame_armed;

    // The first frame_start after reset begins frame 0; only later ones mark a completed frame.
    always_ff @(posedge i_pixel_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_frame_count <= '0;
            r_frame_armed <= 1'b0;
        end else if (w_frame_start_next) begin
            r_frame_armed <= 1'b1;
            if (r_frame_armed) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign o_frame_count = r_frame_count;
`endif

endmodule
